// File: rtl/key_pkg.sv
// -----------------------------------------------------------------------------
// key_pkg
// Shared definitions for the push-button debouncer.
//   key_state_t  : per-channel debounce FSM state, 2-bit encoding
//   CNT_W_DEF    : default width of the per-channel cycle counter
//   DEB_CNT_DEF  : default stable cycles needed to accept a change
//                  (20 ms at 50 MHz)
//   LONG_CNT_DEF : default held cycles after acceptance that flag a long
//                  press (0.2 s at 50 MHz)
// -----------------------------------------------------------------------------
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_DBNC   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_DBNC = 2'd3
    } key_state_t;

    localparam int unsigned CNT_W_DEF = 24;

    localparam logic [CNT_W_DEF-1:0] DEB_CNT_DEF  = 24'd1_000_000;
    localparam logic [CNT_W_DEF-1:0] LONG_CNT_DEF = 24'd10_000_000;

endpackage : key_pkg

// File: rtl/key_debounce_ch.sv
// -----------------------------------------------------------------------------
// key_debounce_ch
// One debounce channel: 2-flop synchronizer, saturating stability counter and
// a four-state FSM turning a bouncing active-low pin into a clean level plus
// one-cycle press/release pulses.
// Optional long-press detection is compiled in with `define KEY_LONG_PRESS_EN;
// without it o_long is tied to 0 and the counter stays 0 while pressed.
//
// Ports
//   i_clk     : system clock
//   i_rst     : synchronous active-high reset
//   i_key     : raw key pin, 0 = pressed, asynchronous to i_clk
//   o_value   : debounced key level, 0 = pressed
//   o_press   : one-cycle pulse when a press is accepted
//   o_release : one-cycle pulse when a release is accepted
//   o_long    : one-cycle pulse when a press has been held LONG_CNT cycles
// -----------------------------------------------------------------------------
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int unsigned      CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEB_CNT  = DEB_CNT_DEF,
    parameter logic [CNT_W-1:0] LONG_CNT = LONG_CNT_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_value,
    output logic o_press,
    output logic o_release,
    output logic o_long
);

    logic             r_sync1;
    logic             r_sync2;
    key_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_value;
    logic             r_press;
    logic             r_release;
    logic             w_keyS;
    logic [CNT_W-1:0] w_cntInc;

`ifdef KEY_LONG_PRESS_EN
    logic r_long;
    logic r_longDone;
`else
    logic w_unusedLong;
`endif

    assign w_keyS   = r_sync2;
    assign w_cntInc = r_cnt + CNT_W'(1);

    // Two-flop synchronizer. Resets to 1 (released) so that a key held
    // through reset is seen as a fresh press and debounced from scratch.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce FSM. Pulses default low every cycle so each event is exactly
    // one cycle wide. The counter never runs past DEB_CNT in the debounce
    // states because reaching it always forces a state change; the >=
    // compare keeps that true even for a DEB_CNT of 0.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_value   <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long     <= 1'b0;
            r_longDone <= 1'b0;
`endif
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
            r_long    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (!w_keyS) begin
                        r_state <= PRESS_DBNC;
                        r_cnt   <= CNT_W'(1);
                    end else begin
                        r_cnt   <= '0;
                    end
                end
                PRESS_DBNC: begin
                    if (w_keyS) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DEB_CNT) begin
                        r_state <= PRESSED;
                        r_value <= 1'b0;
                        r_press <= 1'b1;
                        r_cnt   <= '0;
`ifdef KEY_LONG_PRESS_EN
                        r_longDone <= 1'b0;
`endif
                    end else begin
                        r_cnt   <= w_cntInc;
                    end
                end
                PRESSED: begin
                    if (w_keyS) begin
                        r_state <= RELEASE_DBNC;
                        r_cnt   <= CNT_W'(1);
                    end else begin
`ifdef KEY_LONG_PRESS_EN
                        if (r_cnt < LONG_CNT) begin
                            r_cnt <= w_cntInc;
                            if (w_cntInc == LONG_CNT && !r_longDone) begin
                                r_long     <= 1'b1;
                                r_longDone <= 1'b1;
                            end
                        end
`else
                        r_cnt <= '0;
`endif
                    end
                end
                RELEASE_DBNC: begin
                    if (!w_keyS) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt >= DEB_CNT) begin
                        r_state   <= IDLE;
                        r_value   <= 1'b1;
                        r_release <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt     <= w_cntInc;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_value   = r_value;
    assign o_press   = r_press;
    assign o_release = r_release;

    // Without the long-press feature the threshold is only referenced here so
    // the parameter list stays identical between builds.
`ifdef KEY_LONG_PRESS_EN
    assign o_long = r_long;
`else
    assign w_unusedLong = ^LONG_CNT;
    assign o_long       = 1'b0;
`endif

endmodule : key_debounce_ch

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Debouncer for the board push-buttons (active-low, bouncing). Produces clean
// key levels and one-cycle press/release (and optionally long-press) events
// for downstream blocks. Channels are fully independent; one key_debounce_ch
// per key.
// Optional feature macro: KEY_LONG_PRESS_EN (long-press pulse on key_long).
//
// Ports
//   sys_clk     : system clock
//   sys_rst     : synchronous active-high reset
//   key_in      : raw key pins, 0 = pressed, asynchronous to sys_clk
//   key_value   : debounced key levels, 0 = pressed
//   key_press   : one-cycle pulse per key when a press is accepted
//   key_release : one-cycle pulse per key when a release is accepted
//   key_long    : one-cycle long-press pulse per key (0 when compiled out)
// -----------------------------------------------------------------------------
module key_debounce
    import key_pkg::*;
#(
    parameter int unsigned      NUM_KEYS = 4,
    parameter int unsigned      CNT_W    = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEB_CNT  = DEB_CNT_DEF,
    parameter logic [CNT_W-1:0] LONG_CNT = LONG_CNT_DEF
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_value,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    // One self-contained channel per key; nothing is shared between them.
    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .CNT_W    (CNT_W),
            .DEB_CNT  (DEB_CNT),
            .LONG_CNT (LONG_CNT)
        ) u_ch (
            .i_clk     (sys_clk),
            .i_rst     (sys_rst),
            .i_key     (key_in[i]),
            .o_value   (key_value[i]),
            .o_press   (key_press[i]),
            .o_release (key_release[i]),
            .o_long    (key_long[i])
        );
    end

endmodule : key_debounce

// File: tb/tb_key_debounce.sv
// -----------------------------------------------------------------------------
// tb_key_debounce
// Scoreboard bench for key_debounce with DEB_CNT=10, LONG_CNT=50, 4 keys.
// A reference model samples the inputs on every clock edge and pushes the
// expected event (edge number, pulses, resulting key levels) into a queue;
// an independent monitor pops and compares whenever the DUT shows a pulse.
// -----------------------------------------------------------------------------
module tb_key_debounce;

    localparam int NK   = 4;
    localparam int DEB  = 10;
    localparam int LONG = 50;

    logic          sys_clk;
    logic          sys_rst;
    logic [NK-1:0] key_in;
    logic [NK-1:0] key_value;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;

    typedef struct {
        int            edgeNo;
        logic [NK-1:0] press;
        logic [NK-1:0] rel;
        logic [NK-1:0] lng;
        logic [NK-1:0] value;
    } ev_t;

    ev_t expQ[$];
    int  edgeCount = 0;
    int  compared  = 0;
    int  mismatched = 0;

    key_debounce #(
        .NUM_KEYS (NK),
        .CNT_W    (24),
        .DEB_CNT  (24'd10),
        .LONG_CNT (24'd50)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key_value   (key_value),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    // 50 MHz clock
    initial begin
        sys_clk = 1'b0;
        forever #10 sys_clk = ~sys_clk;
    end

    // Reference model. Works from the rules directly: a key level is accepted
    // once the synchronized input has disagreed with the current level for
    // DEB+1 consecutive edges; the synchronized input is the pin as sampled
    // two edges earlier (released during/just after reset).
    bit mS1[NK];
    bit mS2[NK];
    bit mPrevKs[NK];
    bit mValue[NK];
    bit mLongDone[NK];
    int mRun[NK];
    int mHold[NK];

    always @(posedge sys_clk) begin
        ev_t ev;
        bit  ks;
        edgeCount++;
        ev.edgeNo = edgeCount;
        ev.press  = '0;
        ev.rel    = '0;
        ev.lng    = '0;
        ev.value  = '0;
        for (int c = 0; c < NK; c++) begin
            if (sys_rst) begin
                mS1[c]       = 1'b1;
                mS2[c]       = 1'b1;
                mPrevKs[c]   = 1'b1;
                mValue[c]    = 1'b1;
                mLongDone[c] = 1'b0;
                mRun[c]      = 0;
                mHold[c]     = 0;
            end else begin
                ks     = mS2[c];
                mS2[c] = mS1[c];
                mS1[c] = key_in[c];
`ifdef KEY_LONG_PRESS_EN
                if (!mValue[c]) begin
                    if (!ks && !mPrevKs[c]) begin
                        if (mHold[c] < LONG) begin
                            mHold[c]++;
                            if (mHold[c] == LONG && !mLongDone[c]) begin
                                ev.lng[c]    = 1'b1;
                                mLongDone[c] = 1'b1;
                            end
                        end
                    end else if (ks) begin
                        mHold[c] = 0;
                    end
                end
`endif
                if (ks != mValue[c]) begin
                    mRun[c]++;
                    if (mRun[c] == DEB + 1) begin
                        mValue[c] = ks;
                        mRun[c]   = 0;
                        if (!ks) begin
                            ev.press[c]  = 1'b1;
                            mHold[c]     = 0;
                            mLongDone[c] = 1'b0;
                        end else begin
                            ev.rel[c] = 1'b1;
                        end
                    end
                end else begin
                    mRun[c] = 0;
                end
                mPrevKs[c] = ks;
            end
            ev.value[c] = mValue[c];
        end
        if ((ev.press | ev.rel | ev.lng) != '0)
            expQ.push_back(ev);
    end

    // Monitor: on the falling edge after each active edge, any DUT pulse is
    // matched against the oldest expected event; an expected event whose edge
    // has passed without a DUT pulse is reported as missing.
    always @(negedge sys_clk) begin
        ev_t e;
        if ((key_press | key_release | key_long) != '0) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL unexpected_event@%0d: got press=%b rel=%b long=%b, required none",
                         edgeCount, key_press, key_release, key_long);
            end else begin
                e = expQ.pop_front();
                if (e.edgeNo != edgeCount || e.press != key_press || e.rel != key_release ||
                    e.lng != key_long || e.value != key_value) begin
                    mismatched++;
                    $display("[TB] FAIL event@%0d: got press=%b rel=%b long=%b value=%b, required @%0d press=%b rel=%b long=%b value=%b",
                             edgeCount, key_press, key_release, key_long, key_value,
                             e.edgeNo, e.press, e.rel, e.lng, e.value);
                end
            end
        end else if (expQ.size() != 0 && expQ[0].edgeNo <= edgeCount) begin
            e = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL missing_event@%0d: got no pulse, required press=%b rel=%b long=%b",
                     e.edgeNo, e.press, e.rel, e.lng);
        end
    end

    // Holds the given key/reset levels for a number of clock cycles.
    task automatic applyStimulus(input logic [NK-1:0] keys, input logic rst, input int cycles);
        repeat (cycles) begin
            @(negedge sys_clk);
            key_in  = keys;
            sys_rst = rst;
        end
    endtask

    // Direct comparison against a bench constant.
    task automatic checkOutput(input string name, input logic [NK-1:0] actual,
                               input logic [NK-1:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %b, required %b", name, actual, required);
        end
    endtask

    int            remain[NK];
    logic [NK-1:0] level;

    initial begin
        key_in  = '1;
        sys_rst = 1'b1;
        applyStimulus(4'b1111, 1'b1, 3);
        checkOutput("reset_value",   key_value,   4'b1111);
        checkOutput("reset_press",   key_press,   4'b0000);
        checkOutput("reset_release", key_release, 4'b0000);
        checkOutput("reset_long",    key_long,    4'b0000);
        applyStimulus(4'b1111, 1'b0, 5);

        // Clean press on key 0, then a short release glitch and a real release.
        applyStimulus(4'b1110, 1'b0, 30);
        applyStimulus(4'b1111, 1'b0, 4);
        applyStimulus(4'b1110, 1'b0, 6);
        applyStimulus(4'b1111, 1'b0, 30);

        // Bounce rejection on key 1, then a long enough press.
        applyStimulus(4'b1101, 1'b0, 6);
        applyStimulus(4'b1111, 1'b0, 2);
        applyStimulus(4'b1101, 1'b0, 5);
        applyStimulus(4'b1111, 1'b0, 20);
        checkOutput("bounce_value", key_value, 4'b1111);
        applyStimulus(4'b1101, 1'b0, 15);
        applyStimulus(4'b1111, 1'b0, 30);

        // All keys together, released one at a time.
        applyStimulus(4'b0000, 1'b0, 20);
        checkOutput("all_pressed_value", key_value, 4'b0000);
        applyStimulus(4'b0001, 1'b0, 20);
        applyStimulus(4'b0011, 1'b0, 20);
        applyStimulus(4'b0111, 1'b0, 20);
        applyStimulus(4'b1111, 1'b0, 20);

        // Reset in the middle of debouncing key 2 while it stays held.
        applyStimulus(4'b1011, 1'b0, 8);
        applyStimulus(4'b1011, 1'b1, 1);
        applyStimulus(4'b1011, 1'b0, 1);
        checkOutput("midreset_value", key_value, 4'b1111);
        applyStimulus(4'b1011, 1'b0, 30);
        applyStimulus(4'b1111, 1'b0, 30);

        // Key 3 held well beyond the long-press threshold.
        applyStimulus(4'b0111, 1'b0, 200);
        applyStimulus(4'b1111, 1'b0, 30);

        // Randomised per-key hold times, mixing bounces and stable levels,
        // with an occasional reset.
        level = '1;
        for (int c = 0; c < NK; c++) remain[c] = $urandom_range(1, 30);
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NK; c++) begin
                remain[c]--;
                if (remain[c] <= 0) begin
                    level[c]  = ~level[c];
                    remain[c] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8)
                                                            : $urandom_range(9, 70);
                end
            end
            applyStimulus(level, ($urandom_range(0, 699) == 0), 1);
        end

        applyStimulus(4'b1111, 1'b0, 40);
        checkOutput("final_value", key_value, 4'b1111);
        while (expQ.size() != 0) begin
            ev_t e;
            e = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL leftover_event@%0d: got no pulse, required press=%b rel=%b long=%b",
                     e.edgeNo, e.press, e.rel, e.lng);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_key_debounce
